// File: rtl/sha256_pkg.sv
// Shared SHA-256 scheduler types and constants.
// Initial hash value, round count, FSM states and 8x32 word packing.
package sha256_pkg;

    localparam int ROUNDS = 64;

    typedef logic [7:0][31:0] word_pack_t;

    localparam word_pack_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sha256_round_scheduler_if.sv
// Scheduler bus: padder handshake, w-schedule controls,
// round datapath handoff and chaining hash.
interface sha256_round_scheduler_if #(
    parameter int W_LENGTH = 64
);
    localparam int IDX_W = $clog2(W_LENGTH) + 1;

    logic             start;
    logic             first_block;
    logic             abort;
    logic [255:0]     working_vars;
    logic             busy;
    logic             load_working;
    logic [255:0]     working_init;
    logic             w_enable;
    logic [IDX_W-1:0] w_vector_index;
    logic             w_index_complete;
    logic             round_enable;
    logic [255:0]     hash_vector;
    logic             done;
    logic             digest_valid;

    modport master (
        input  start, first_block, abort, working_vars,
        output busy, load_working, working_init,
        output w_enable, w_vector_index, w_index_complete,
        output round_enable, hash_vector, done, digest_valid
    );

    modport slave (
        output start, first_block, abort, working_vars,
        input  busy, load_working, working_init,
        input  w_enable, w_vector_index, w_index_complete,
        input  round_enable, hash_vector, done, digest_valid
    );

endinterface

// File: rtl/sha256_hash_update.sv
// End-of-block feed-forward: eight independent mod-2^32 adders.
module sha256_hash_update
    import sha256_pkg::*;
(
    input  word_pack_t base,
    input  word_pack_t working_vars,
    output word_pack_t sum
);

    for (genvar i = 0; i < 8; i++) begin : g_add
        assign sum[i] = base[i] + working_vars[i];
    end

endmodule

// File: rtl/sha256_round_scheduler.sv
// Per-block SHA-256 compression sequencer; owns chaining hash H
// and drives the w-schedule generator and round datapath.
module sha256_round_scheduler
    import sha256_pkg::*;
#(
    parameter int W_LENGTH = ROUNDS
) (
    input  logic                      clock,
    input  logic                      reset,
    sha256_round_scheduler_if.master  bus
);

    localparam int IDX_W = $clog2(W_LENGTH) + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(W_LENGTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fb_q;
    logic             dv_q;
    logic             accept;
    word_pack_t       h_q, base_q, init_val, sum;

    assign init_val = fb_q ? SHA256_IV : h_q;

    sha256_hash_update u_update (
        .base         (base_q),
        .working_vars (bus.working_vars),
        .sum          (sum)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        accept  = (state_q == ST_IDLE || state_q == ST_DONE)
                  && bus.start && !bus.abort;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_INIT;
            end
            ST_INIT: begin
                state_d = bus.abort ? ST_IDLE : ST_ROUND;
            end
            ST_ROUND: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == LAST) begin
                    state_d = ST_UPDATE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                state_d = bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_d = accept ? ST_INIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fb_q    <= 1'b1;
            dv_q    <= 1'b0;
            h_q     <= SHA256_IV;
            base_q  <= SHA256_IV;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                fb_q <= bus.first_block;
                if (bus.first_block) dv_q <= 1'b0;
            end
            if (state_q == ST_INIT) base_q <= init_val;
            // H only commits when UPDATE completes; abort leaves it intact
            if (state_q == ST_UPDATE && !bus.abort) begin
                h_q  <= sum;
                dv_q <= 1'b1;
            end
        end
    end

    assign bus.busy             = state_q == ST_INIT
                                  || state_q == ST_ROUND
                                  || state_q == ST_UPDATE;
    assign bus.load_working     = state_q == ST_INIT;
    assign bus.working_init     = init_val;
    assign bus.w_enable         = state_q == ST_ROUND;
    assign bus.round_enable     = state_q == ST_ROUND;
    assign bus.w_vector_index   = idx_q;
    assign bus.w_index_complete = state_q == ST_ROUND && idx_q == LAST;
    assign bus.hash_vector      = h_q;
    assign bus.done             = state_q == ST_DONE;
    assign bus.digest_valid     = dv_q;

endmodule

// File: doc/sha256_round_scheduler.md
Name: sha256_round_scheduler

Overview:
Sequences one SHA-256 compression per 512-bit block. It drives the message-schedule generator (w_enable, w_vector_index) and the round datapath through W_LENGTH rounds. It holds the 256-bit chaining hash H and performs the end-of-block H += {a..h} feed-forward. It sits between the message padder (start/first_block) and the w-schedule and round datapath modules.

Parameters:
W_LENGTH, 64, number of compression rounds (w words) per block; index width is $clog2(W_LENGTH)+1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request compression of the presented block; accepted only in IDLE or DONE
first_block  input  1  sampled with accepted start; 1 = chain from IV, 0 = chain from current H
abort  input  1  synchronous cancel; returns to IDLE, H untouched
working_vars  input  256  {a,b,c,d,e,f,g,h} from round datapath, a in [255:224]; sampled in UPDATE
busy  output  1  high in INIT, ROUND and UPDATE
load_working  output  1  one-cycle pulse in INIT; datapath loads working_init into a..h
working_init  output  256  chaining value for this block (IV or H)
w_enable  output  1  enable to w-schedule generator; high only in ROUND
w_vector_index  output  $clog2(W_LENGTH)+1  current round/w index, 0..W_LENGTH-1
w_index_complete  output  1  high in the ROUND cycle where w_vector_index == W_LENGTH-1
round_enable  output  1  datapath performs one round this cycle; equals w_enable
hash_vector  output  256  chaining/digest register H, word H0 in [255:224]
done  output  1  one-cycle pulse in DONE
digest_valid  output  1  set on first done after reset, cleared by reset or an accepted first_block start

Behaviour:
- Reset (async): state IDLE; H = IV; busy, load_working, w_enable, round_enable, w_index_complete, done, digest_valid = 0; w_vector_index = 0; working_init = IV.
- States: IDLE, INIT, ROUND, UPDATE, DONE.
- IDLE: start & !abort -> INIT; latch first_block into fb_q.
- INIT (1 cycle): load_working=1; working_init = fb_q ? IV : H; the same value is latched as base. -> ROUND with index 0.
- ROUND (W_LENGTH cycles): w_enable = round_enable = 1; index increments by 1 per cycle. At index W_LENGTH-1, w_index_complete=1 and next state is UPDATE; index returns to 0.
- UPDATE (1 cycle): H[i] <= base[i] + working_vars[i] for each 32-bit word i, modulo 2^32 with no carry between words.
- DONE (1 cycle): done=1; digest_valid=1. start -> INIT (back-to-back, first_block resampled); else -> IDLE.
- Latency: start accepted at edge T; INIT at T+1; rounds T+2..T+W_LENGTH+1; UPDATE at T+W_LENGTH+2; done at T+W_LENGTH+3 (T+67 for default). hash_vector shows the new H in the done cycle.
- start while busy: ignored, no queueing.
- abort in INIT/ROUND/UPDATE: next state IDLE, H and digest_valid unchanged, no done. abort wins over start in the same cycle. abort in DONE: done still asserted this cycle, next state IDLE.
- first_block=1 start: clears digest_valid at the accepting edge.
- first_block=0 start after reset with no prior block: chains from H = IV (identical to first_block=1, but digest_valid is not cleared).
- Async reset mid-ROUND: immediate return to reset values; no partial H update.

Decomposition:
- Shared package sha256_pkg: SHA256_IV (8x32: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19); round-count localparam; state enum typedef; 256-bit word-pack typedef.
- One sub-module: sha256_hash_update, 8 parallel 32-bit modular adders (base + working_vars), purely combinational; registered here.

Test Plan:
- Reset then start, first_block=1, working_vars=0 -> load_working at T+1 with working_init=IV; w_vector_index 0..63 at T+2..T+65; w_index_complete only at T+65; done at T+67; hash_vector=IV; digest_valid=1.
- Feed-forward wrap: first_block=1, working_vars all words FFFFFFFF -> H0=6a09e666, H7=5be0cd18 (each IV word minus 1), no cross-word carry.
- Chaining: second start with first_block=0 -> working_init equals previous hash_vector. Start asserted in the DONE cycle -> INIT on the very next cycle.
- Abort at round 30 -> IDLE next cycle, no done, hash_vector and digest_valid unchanged; abort+start together in IDLE -> stays IDLE.
- start pulses during ROUND -> ignored, exactly one done. Async reset asserted at index 40 -> outputs return to reset values without a clock edge; hash_vector=IV.
- Mock round datapath computing real SHA-256 rounds, message "abc" -> hash_vector = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
